seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadowed digits, BCD/hex decode, leading-zero blanking.
// Optional blink support is compiled in with the SEG7_BLINK_EN macro.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lzb_en,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]                cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]   dig_q, dig_d;
    logic [NUM_DIGITS-1:0]        dp_q, dp_d;
    logic [7:0]                   seg_q, seg_d;
    logic [NUM_DIGITS-1:0]        sel_q, sel_d;
    logic                         tick;
    logic [NUM_DIGITS-1:0]        zero_hi;
    logic                         zacc;
    logic                         blank;
    logic [3:0]                   nib;
`ifdef SEG7_BLINK_EN
    logic [7:0]                   blk_q, blk_d;
    logic                         phase_q, phase_d;
`endif

    function automatic logic [6:0] seg7_decode(input logic [3:0] n, input logic hex);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return hex ? 7'h77 : 7'h40;
            4'hB: return hex ? 7'h7C : 7'h40;
            4'hC: return hex ? 7'h39 : 7'h40;
            4'hD: return hex ? 7'h5E : 7'h40;
            4'hE: return hex ? 7'h79 : 7'h40;
            default: return hex ? 7'h71 : 7'h40;
        endcase
    endfunction

    // Prescaler, digit index and shadow capture
    always_comb begin
        tick  = (cnt_q == PW'(SCAN_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        dig_d = load ? digits_in : dig_q;
        dp_d  = load ? dp_in : dp_q;
    end

    // zero_hi[i]: digit i and every more-significant digit are zero
    always_comb begin
        zero_hi = '0;
        zacc    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zacc       = zacc && (dig_q[i] == 4'h0);
            zero_hi[i] = zacc;
        end
    end

    always_comb begin
        nib   = dig_q[idx_q];
        blank = lzb_en && (idx_q != '0) && zero_hi[idx_q];
        seg_d = {dp_q[idx_q], blank ? 7'h00 : seg7_decode(nib, hex_mode)};
        sel_d = NUM_DIGITS'(1) << idx_q;
`ifdef SEG7_BLINK_EN
        if (phase_q && blink_mask[idx_q]) seg_d = 8'h00;
        blk_d   = tick ? blk_q + 1'b1 : blk_q;
        phase_d = (tick && blk_q == 8'hFF) ? ~phase_q : phase_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            dp_q    <= '0;
            seg_q   <= '0;
            sel_q   <= '0;
`ifdef SEG7_BLINK_EN
            blk_q   <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
`ifdef SEG7_BLINK_EN
            blk_q   <= blk_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4): vector table plus scan, load and reset sequences.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic          hex_mode = 1'b0;
    logic          lzb_en = 1'b0;
    logic [7:0]    seg_out;
    logic [3:0]    dig_sel;
`ifdef SEG7_BLINK_EN
    logic [3:0]    blink_mask = '0;
`endif

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .hex_mode  (hex_mode),
        .lzb_en    (lzb_en),
`ifdef SEG7_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out   (seg_out),
        .dig_sel   (dig_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edges;

    // Edges since reset release; output at edge n shows digit ((n-1)/SD)%ND
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    function automatic int cur_idx();
        return ((edges - 1) / SD) % ND;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_slot(input string name, input logic [7:0] exp_seg);
        logic [7:0] one;
        one = 8'(1) << cur_idx();
        check({name, ".sel"}, {4'h0, dig_sel}, one);
        check({name, ".seg"}, seg_out, exp_seg);
    endtask

    // Wait (bounded) for a negedge at slot phase ph, optionally on digit idx
    task automatic wait_phase(input int ph, input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(((edges - 1) % SD) == ph && (idx < 0 || cur_idx() == idx)) && n < 64);
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: timeout got phase %0d expected %0d", (edges - 1) % SD, ph);
        end
    endtask

    typedef struct {
        logic [15:0]     digs;
        logic [3:0]      dp;
        logic            hex;
        logic            lzb;
        logic [3:0][7:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    typedef struct {
        int         dig;
        logic [7:0] seg;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    logic [3:0][7:0] lut1234;
    logic [3:0][7:0] lut5678;

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66}};
        vecs[1] = '{16'h00A5, 4'b0000, 1'b0, 1'b1, {8'h00, 8'h00, 8'h40, 8'h6D}};
        vecs[2] = '{16'h00A5, 4'b0000, 1'b1, 1'b1, {8'h00, 8'h00, 8'h77, 8'h6D}};
        vecs[3] = '{16'h0000, 4'b0100, 1'b0, 1'b1, {8'h00, 8'h80, 8'h00, 8'h3F}};
        vecs[4] = '{16'hFEDC, 4'b0000, 1'b1, 1'b0, {8'h71, 8'h79, 8'h5E, 8'h39}};
        vecs[5] = '{16'h9876, 4'b1010, 1'b0, 1'b1, {8'hEF, 8'h7F, 8'h87, 8'h7D}};
        vecs[6] = '{16'h0B00, 4'b0000, 1'b0, 1'b1, {8'h00, 8'h40, 8'h3F, 8'h3F}};
        vecs[7] = '{16'h0050, 4'b0001, 1'b1, 1'b0, {8'h3F, 8'h3F, 8'h6D, 8'hBF}};
        lut1234 = {8'h06, 8'h5B, 8'h4F, 8'h66};
        lut5678 = {8'h6D, 8'h7D, 8'h07, 8'h7F};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.seg", seg_out, 8'h00);
        check("reset.sel", {4'h0, dig_sel}, 8'h00);
        rst_n = 1'b1;

        // Free-running scan, nothing loaded
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_slot($sformatf("scan%0d", i), 8'h3F);
        end

        // Load lands on the current slot one cycle later
        wait_phase(0, -1);
        digits_in = 16'h1234;
        load = 1'b1;
        check("ld_pre", seg_out, 8'h3F);
        @(negedge clk);
        load = 1'b0;
        check("ld_old", seg_out, 8'h3F);
        @(negedge clk);
        check_slot("ld_new", lut1234[cur_idx()]);

        // Load coincident with a tick: new index and new data appear together
        wait_phase(2, -1);
        digits_in = 16'h5678;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_slot("coinc_old", lut1234[cur_idx()]);
        @(negedge clk);
        check_slot("coinc_new", lut5678[cur_idx()]);

        // Reset mid-slot on digit 2, with a load pending that must be dropped
        digits_in = 16'h1234;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_phase(1, 2);
        rst_n = 1'b0;
        digits_in = 16'h4321;
        load = 1'b1;
        #1;
        check("rst_async.seg", seg_out, 8'h00);
        check("rst_async.sel", {4'h0, dig_sel}, 8'h00);
        @(negedge clk);
        load = 1'b0;
        check("rst_hold.seg", seg_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check_slot("rst_rel0", 8'h3F);
        wait_phase(1, 1);
        check_slot("rst_rel1", 8'h3F);

        // Table vectors via scoreboard
        for (int v = 0; v < 8; v++) begin
            int c;
            int bound;
            sb_t e;
            @(negedge clk);
            digits_in = vecs[v].digs;
            dp_in     = vecs[v].dp;
            hex_mode  = vecs[v].hex;
            lzb_en    = vecs[v].lzb;
            load      = 1'b1;
            @(negedge clk);
            load = 1'b0;
            c = cur_idx();
            for (int k = 1; k <= ND; k++) begin
                e.dig = (c + k) % ND;
                e.seg = vecs[v].exp[(c + k) % ND];
                sb.push_back(e);
            end
            bound = 0;
            while (sb.size() > 0 && bound < 40) begin
                @(negedge clk);
                bound++;
                if (((edges - 1) % SD) == 2 && cur_idx() == sb[0].dig) begin
                    e = sb.pop_front();
                    check_slot($sformatf("vec%0d.d%0d", v, e.dig), e.seg);
                end
            end
            if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL vec%0d.timeout: got %0d pending expected 0", v, sb.size());
                sb.delete();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
